condicionador_sensores: RTL and testbench
=========================================

# condicionador_sensores

Conditioning stage directly upstream of the reverse-decision logic. It synchronizes and debounces the four raw proximity sensors (front, right, left, rear) and drives the clean `Sensor_*` levels that the decision logic consumes. It also generates that logic's `Saida_Erro` input: a blocked/faulty-sensor flag raised when all four filtered sensors stay active for a configured number of cycles.

## Interface
- `DEBOUNCE_CICLOS`, default 4: consecutive mismatching cycles before a filtered sensor changes. Legal range ≥2.
- `ERRO_CICLOS`, default 8: consecutive all-active cycles before `Saida_Erro` rises. Legal range ≥2.
- `Clock` input, 1 bit: single clock; all state updates on the rising edge.
- `Reset_n` input, 1 bit: asynchronous, active-low reset.
- `Sensor_Frontal_Bruto`, `Sensor_Direito_Bruto`, `Sensor_Esquerdo_Bruto`, `Sensor_Trazeiro_Bruto` inputs, 1 bit each: raw asynchronous sensor levels.
- `Limpar_Erro` input, 1 bit: synchronous error-clear request, sampled on the clock edge.
- `Sensor_Frontal`, `Sensor_Direito`, `Sensor_Esquerdo`, `Sensor_Trazeiro` outputs, 1 bit each: registered, debounced sensor levels.
- `Saida_Erro` output, 1 bit: registered blocked/fault flag.

## Operation
- **Synchronizer**
  - Each raw input passes through a 2-flop synchronizer (`s1`, then `s2`).
  - All flops reset to 0.
- **Debounce**
  - Each channel holds a stable register `S` and a counter `C` of width `$clog2(DEBOUNCE_CICLOS)`.
  - If `s2 == S`: `C <= 0`.
  - If `s2 != S` and `C == DEBOUNCE_CICLOS-1`: `S <= s2` and `C <= 0`.
  - If `s2 != S` otherwise: `C <= C+1`.
  - Each `Sensor_*` output is driven directly by its `S` register.
  - Channels are independent of each other.
- **Error FSM**
  - Input condition: `Bloqueio = &{S_frontal, S_direito, S_esquerdo, S_trazeiro}`.
  - Counter `E` has width `$clog2(ERRO_CICLOS)`.
  - `OK`: if `Bloqueio`, go to `SUSPEITO` and set `E <= 1`.
  - `SUSPEITO`:
    - if `!Bloqueio`, go to `OK` and set `E <= 0`;
    - else if `E == ERRO_CICLOS-1`, go to `ERRO`;
    - else `E <= E+1`.
  - `ERRO`: exit rule depends on configuration (see below).
  - `Saida_Erro` is a registered Moore output, equal to 1 exactly while the state is `ERRO`.
  - `Limpar_Erro` is ignored in `OK` and `SUSPEITO`.

## Timing
- **Reset values:** all four `Sensor_*` = 0, `Saida_Erro` = 0, state = `OK`, all counters = 0.
  - Assertion of `Reset_n` takes effect immediately, including mid-debounce or mid-`SUSPEITO`; in-progress counts are discarded.
- **Debounce latency:** a raw level captured by `s1` at edge 1 appears on `Sensor_*` at edge 2+`DEBOUNCE_CICLOS`, provided the level holds.
  - With the default of 4, this is edge 6.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CICLOS` cycles, as seen at `s2`, never reaches `Sensor_*`. The counter resets on the first matching cycle.
- **Error latency:** if `Bloqueio` first becomes true after edge t, `Saida_Erro` rises at edge t+`ERRO_CICLOS`.
  - If `Bloqueio` drops at any edge before that, the FSM returns to `OK` and the count restarts from zero.
- **Simultaneous events in `ERRO` (macro enabled):** if `Limpar_Erro` and `Bloqueio` are both 1, the FSM goes to `OK` and `Saida_Erro` falls. It re-enters `SUSPEITO` on the next edge, and the full `ERRO_CICLOS` count is required again.

## Configuration
- Macro: `CONDICIONADOR_TRAVA_ERRO_EN`.
- **Defined (sticky error):**
  - `ERRO` exits to `OK` only on an edge where `Limpar_Erro == 1`, regardless of `Bloqueio`.
  - `Saida_Erro` falls on that same edge.
- **Undefined (auto-clear):**
  - `ERRO` exits to `OK` on the first edge where `Bloqueio == 0`.
  - `Limpar_Erro` is ignored entirely and may be left unconnected.

## Test plan
Defaults apply: `DEBOUNCE_CICLOS`=4, `ERRO_CICLOS`=8.
- **Debounce rise:** `Sensor_Frontal_Bruto` 0→1 sampled at edge 1 and held → `Sensor_Frontal` goes 1 at edge 6; other outputs stay 0; `Saida_Erro` stays 0.
- **Glitch rejection:** `Sensor_Direito_Bruto` high for 3 cycles then low → `Sensor_Direito` stays 0 throughout.
- **Error raise, sticky (macro defined):**
  - All four raw inputs go high together and hold → all `Sensor_*` = 1 at edge 6; `Saida_Erro` = 1 at edge 14.
  - Then drop `Sensor_Trazeiro_Bruto` → `Saida_Erro` stays 1.
  - Pulse `Limpar_Erro` for one cycle → `Saida_Erro` goes 0 on that edge.
- **Auto-clear (macro undefined):** same stimulus as the previous scenario → `Saida_Erro` goes 0 one edge after `Sensor_Trazeiro` falls; `Limpar_Erro` pulses before that point have no effect.
- **Near-miss:** all four filtered sensors high for exactly 7 cycles, then `Sensor_Esquerdo` falls → `Saida_Erro` never rises; state returns to `OK`.
  - A subsequent blocked period must again take a full 8 cycles to raise the error.
- **Reset mid-operation:** `Reset_n` low for 1 cycle during `SUSPEITO`, with sensors held high → all outputs 0 immediately. After release, `Sensor_*` rise again 6 edges later and `Saida_Erro` 8 edges after that.

Source files
------------

// File: rtl/condicionador_sensores.sv
// Sensor conditioning: 2-flop sync + debounce per channel, blocked-sensor error FSM.
// Define CONDICIONADOR_TRAVA_ERRO_EN for a sticky error cleared only by Limpar_Erro.
module condicionador_sensores #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int ERRO_CICLOS     = 8
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Sensor_Frontal_Bruto,
    input  logic Sensor_Direito_Bruto,
    input  logic Sensor_Esquerdo_Bruto,
    input  logic Sensor_Trazeiro_Bruto,
    input  logic Limpar_Erro,
    output logic Sensor_Frontal,
    output logic Sensor_Direito,
    output logic Sensor_Esquerdo,
    output logic Sensor_Trazeiro,
    output logic Saida_Erro
);

    localparam int DW = $clog2(DEBOUNCE_CICLOS);
    localparam int EW = $clog2(ERRO_CICLOS);
    localparam logic [DW-1:0] C_MAX = DW'(DEBOUNCE_CICLOS - 1);
    localparam logic [EW-1:0] E_MAX = EW'(ERRO_CICLOS - 1);

    typedef enum logic [1:0] {
        OK,
        SUSPEITO,
        ERRO
    } estado_t;

    logic [3:0]    bruto;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    s;
    logic [DW-1:0] c [4];
    logic [EW-1:0] e;
    logic          bloqueio;
    estado_t       estado;

    assign bruto = {Sensor_Frontal_Bruto, Sensor_Direito_Bruto,
                    Sensor_Esquerdo_Bruto, Sensor_Trazeiro_Bruto};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s  <= '0;
            for (int i = 0; i < 4; i++) c[i] <= '0;
        end else begin
            s1 <= bruto;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == s[i]) begin
                    c[i] <= '0;
                end else if (c[i] == C_MAX) begin
                    s[i] <= s2[i];
                    c[i] <= '0;
                end else begin
                    c[i] <= c[i] + 1'b1;
                end
            end
        end
    end

    assign Sensor_Frontal  = s[3];
    assign Sensor_Direito  = s[2];
    assign Sensor_Esquerdo = s[1];
    assign Sensor_Trazeiro = s[0];
    assign bloqueio        = &s;

`ifndef CONDICIONADOR_TRAVA_ERRO_EN
    logic unused_limpar;
    assign unused_limpar = Limpar_Erro;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado     <= OK;
            e          <= '0;
            Saida_Erro <= 1'b0;
        end else begin
            unique case (estado)
                OK: begin
                    if (bloqueio) begin
                        estado <= SUSPEITO;
                        e      <= EW'(1);
                    end
                end
                SUSPEITO: begin
                    if (!bloqueio) begin
                        estado <= OK;
                        e      <= '0;
                    end else if (e == E_MAX) begin
                        estado     <= ERRO;
                        Saida_Erro <= 1'b1;
                    end else begin
                        e <= e + 1'b1;
                    end
                end
                ERRO: begin
`ifdef CONDICIONADOR_TRAVA_ERRO_EN
                    if (Limpar_Erro) begin
`else
                    if (!bloqueio) begin
`endif
                        estado     <= OK;
                        e          <= '0;
                        Saida_Erro <= 1'b0;
                    end
                end
                default: begin
                    estado     <= OK;
                    e          <= '0;
                    Saida_Erro <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_condicionador_sensores.sv
// Directed bench for condicionador_sensores with default parameters.
// Outputs checked as {Frontal, Direito, Esquerdo, Trazeiro, Erro}.
module tb_condicionador_sensores;

    logic Clock;
    logic Reset_n;
    logic fb, db, eb, tb;
    logic Limpar_Erro;
    logic Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo, Sensor_Trazeiro;
    logic Saida_Erro;

    int tests = 0;
    int fails = 0;

    condicionador_sensores dut (
        .Clock                 (Clock),
        .Reset_n               (Reset_n),
        .Sensor_Frontal_Bruto  (fb),
        .Sensor_Direito_Bruto  (db),
        .Sensor_Esquerdo_Bruto (eb),
        .Sensor_Trazeiro_Bruto (tb),
        .Limpar_Erro           (Limpar_Erro),
        .Sensor_Frontal        (Sensor_Frontal),
        .Sensor_Direito        (Sensor_Direito),
        .Sensor_Esquerdo       (Sensor_Esquerdo),
        .Sensor_Trazeiro       (Sensor_Trazeiro),
        .Saida_Erro            (Saida_Erro)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {Sensor_Frontal, Sensor_Direito, Sensor_Esquerdo,
               Sensor_Trazeiro, Saida_Erro};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] x;
        Reset_n = 1'b0;
        {fb, db, eb, tb} = 4'b0000;
        Limpar_Erro = 1'b0;
        tick();
        tick();
        chk("reset", 5'b00000);
        Reset_n = 1'b1;

        // single channel rise then fall
        fb = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            x = (n == 6) ? 5'b10000 : 5'b00000;
            chk($sformatf("rise_e%0d", n), x);
        end
        fb = 1'b0;
        repeat (5) tick();
        chk("fall_e5", 5'b10000);
        tick();
        chk("fall_e6", 5'b00000);

        // 3-cycle glitch on Direito
        for (int n = 1; n <= 10; n++) begin
            db = (n <= 3);
            tick();
            chk($sformatf("glitch_e%0d", n), 5'b00000);
        end

        // all blocked -> error at edge 14
        {fb, db, eb, tb} = 4'b1111;
        for (int n = 1; n <= 14; n++) begin
            tick();
            x = (n < 6) ? 5'b00000 : (n < 14) ? 5'b11110 : 5'b11111;
            chk($sformatf("block_e%0d", n), x);
        end

`ifdef CONDICIONADOR_TRAVA_ERRO_EN
        for (int n = 1; n <= 9; n++) begin
            tb = 1'b0;
            Limpar_Erro = (n == 9);
            tick();
            x = {3'b111, n < 6, n < 9};
            chk($sformatf("sticky_e%0d", n), x);
        end
`else
        for (int n = 1; n <= 7; n++) begin
            tb = 1'b0;
            Limpar_Erro = (n == 2);
            tick();
            x = {3'b111, n < 6, n < 7};
            chk($sformatf("auto_e%0d", n), x);
        end
`endif
        Limpar_Erro = 1'b0;

        {fb, db, eb, tb} = 4'b0000;
        repeat (8) tick();
        chk("idle", 5'b00000);

        // near miss: 7 blocked cycles, then full 8 needed again
        for (int n = 1; n <= 30; n++) begin
            {fb, db, tb} = 3'b111;
            eb = !(n >= 8 && n < 17);
            tick();
            x[4] = (n >= 6);
            x[3] = (n >= 6);
            x[2] = (n >= 6) && !(n >= 13 && n < 22);
            x[1] = (n >= 6);
            x[0] = (n >= 30);
            chk($sformatf("near_e%0d", n), x);
        end

        // asynchronous reset from ERRO
        Reset_n = 1'b0;
        #1;
        chk("rst_async", 5'b00000);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            x = (n < 6) ? 5'b00000 : 5'b11110;
            chk($sformatf("rerise_e%0d", n), x);
        end

        // reset during SUSPEITO
        Reset_n = 1'b0;
        #1;
        chk("rst_suspeito", 5'b00000);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            x = (n < 6) ? 5'b00000 : (n < 14) ? 5'b11110 : 5'b11111;
            chk($sformatf("post_rst_e%0d", n), x);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
